fb_demote: RTL and testbench

FB_DEMOTE -- requirements
Module: fb_demote

---
 rtl/fb_demote.sv | 109 ++++++++++
 tb/tb_fb_demote.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_demote.sv
// fb_demote: clamps signed Q4.12 RGB fragments, optionally applies 4x4 ordered
// dither, and packs the result to RGB565 through a two-stage valid/ready pipeline.
module fb_demote #(
  parameter int DITHER_EN = 1,
  parameter int ADDR_W    = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_r,
  input  logic [15:0]       in_g,
  input  logic [15:0]       in_b,
  input  logic [1:0]        in_x_lo,
  input  logic [1:0]        in_y_lo,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_pixel,
  output logic [ADDR_W-1:0] out_addr
);

  localparam logic [11:0] MAX_C = 12'hFFF;

  logic              s1_v, s2_v;
  logic              s1_adv, s2_adv;
  logic [11:0]       s1_r, s1_g, s1_b;
  logic [ADDR_W-1:0] s1_addr;
  logic [11:0]       cl_r, cl_g, cl_b;
  logic [11:0]       dt_r, dt_g, dt_b;
  logic [3:0]        d;

  // Negative values go to zero; anything at or above 1.0 pins to the largest fraction.
  function automatic logic [11:0] clamp(input logic [15:0] v);
    if (v[15])                  return 12'h000;
    else if (v[14:12] != 3'b000) return MAX_C;
    else                        return v[11:0];
  endfunction

  // The 13-bit sum cannot wrap: 0xFFF plus the largest dither offset (120) fits easily.
  function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [6:0] inc);
    logic [12:0] sum;
    sum = {1'b0, a} + {6'b000000, inc};
    return sum[12] ? MAX_C : sum[11:0];
  endfunction

  function automatic logic [3:0] bayer(input logic [1:0] y, input logic [1:0] x);
    case ({y, x})
      4'h0: return 4'd0;   4'h1: return 4'd8;   4'h2: return 4'd2;   4'h3: return 4'd10;
      4'h4: return 4'd12;  4'h5: return 4'd4;   4'h6: return 4'd14;  4'h7: return 4'd6;
      4'h8: return 4'd3;   4'h9: return 4'd11;  4'hA: return 4'd1;   4'hB: return 4'd9;
      4'hC: return 4'd15;  4'hD: return 4'd7;   4'hE: return 4'd13;  default: return 4'd5;
    endcase
  endfunction

  assign s2_adv    = !s2_v || out_ready;
  assign s1_adv    = !s1_v || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_v;

  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
    cl_r = clamp(in_r);
    cl_g = clamp(in_g);
    cl_b = clamp(in_b);
    d    = bayer(in_y_lo, in_x_lo);
    dt_r = cl_r;
    dt_g = cl_g;
    dt_b = cl_b;
    if (DITHER_EN != 0) begin
      dt_r = sat_add(cl_r, {d, 3'b000});
      dt_g = sat_add(cl_g, {1'b0, d, 2'b00});
      dt_b = sat_add(cl_b, {d, 3'b000});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, because out_pixel/out_addr must read zero during reset.
      s1_v      <= 1'b0;
      s1_r      <= '0;
      s1_g      <= '0;
      s1_b      <= '0;
      s1_addr   <= '0;
      s2_v      <= 1'b0;
      out_pixel <= '0;
      out_addr  <= '0;
    end else begin
      // NOTE: non-blocking assignments let S2 capture the S1 value from before this edge.
      if (s1_adv) begin
        s1_v <= in_valid;
        if (in_valid) begin
          s1_r    <= dt_r;
          s1_g    <= dt_g;
          s1_b    <= dt_b;
          s1_addr <= in_addr;
        end
      end
      if (s2_adv) begin
        s2_v <= s1_v;
        if (s1_v) begin
          out_pixel <= {s1_r[11:7], s1_g[11:6], s1_b[11:7]};
          out_addr  <= s1_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_demote.sv
// Testbench for fb_demote: one undithered and one dithered instance share stimulus;
// a queue scoreboard holds expected pixels for both alongside the address.
module tb_fb_demote;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, out_ready;
  logic [15:0]   in_r, in_g, in_b;
  logic [1:0]    in_x_lo, in_y_lo;
  logic [AW-1:0] in_addr;
  logic          in_ready0, in_ready1, out_valid0, out_valid1;
  logic [15:0]   out_pixel0, out_pixel1;
  logic [AW-1:0] out_addr0, out_addr1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0]   p0;
    logic [15:0]   p1;
    logic [AW-1:0] addr;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0] r, g, b;
    logic [1:0]  x, y;
    logic [15:0] e0, e1;
  } vec_t;
  vec_t vecs[8];

  logic          tab_mode = 1'b0;
  logic [15:0]   tab_e0, tab_e1;
  logic          prev_stall = 1'b0;
  logic [15:0]   prev_pix;
  logic [AW-1:0] prev_addr;
  logic          last_acc;

  fb_demote #(.DITHER_EN(0), .ADDR_W(AW)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_x_lo(in_x_lo), .in_y_lo(in_y_lo),
    .in_addr(in_addr), .out_valid(out_valid0), .out_ready(out_ready),
    .out_pixel(out_pixel0), .out_addr(out_addr0)
  );

  fb_demote #(.DITHER_EN(1), .ADDR_W(AW)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_x_lo(in_x_lo), .in_y_lo(in_y_lo),
    .in_addr(in_addr), .out_valid(out_valid1), .out_ready(out_ready),
    .out_pixel(out_pixel1), .out_addr(out_addr1)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    if (s < 0) return 0;
    if (s > 4095) return 4095;
    return s;
  endfunction

  function automatic logic [15:0] model(input logic [15:0] r, g, b,
                                        input logic [1:0] x, y, input bit den);
    int bay[16];
    int dv, rr, gg, bb;
    bay = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
    dv = den ? bay[int'(y) * 4 + int'(x)] : 0;
    rr = clampi(r) + dv * 8;
    gg = clampi(g) + dv * 4;
    bb = clampi(b) + dv * 8;
    if (rr > 4095) rr = 4095;
    if (gg > 4095) gg = 4095;
    if (bb > 4095) bb = 4095;
    return {rr[11:7], gg[11:6], bb[11:7]};
  endfunction

  // Called right after a falling edge with inputs driven; samples just before the rising edge.
  task automatic tick();
    exp_t e;
    #4;
    last_acc = in_valid && in_ready0;
    if (last_acc) begin
      if (tab_mode) e = '{tab_e0, tab_e1, in_addr};
      else e = '{model(in_r, in_g, in_b, in_x_lo, in_y_lo, 1'b0),
                 model(in_r, in_g, in_b, in_x_lo, in_y_lo, 1'b1), in_addr};
      sb.push_back(e);
    end
    if (prev_stall) begin
      check("hold_valid", 32'(out_valid0), 1);
      check("hold_pixel", 32'(out_pixel0), 32'(prev_pix));
      check("hold_addr", 32'(out_addr0), 32'(prev_addr));
    end
    prev_stall = out_valid0 && !out_ready;
    prev_pix   = out_pixel0;
    prev_addr  = out_addr0;
    if (out_valid0 && out_ready) begin
      if (sb.size() == 0) check("spurious_output", 32'(out_valid0), 0);
      else begin
        e = sb.pop_front();
        check("pixel_plain", 32'(out_pixel0), 32'(e.p0));
        check("pixel_dither", 32'(out_pixel1), 32'(e.p1));
        check("addr_plain", 32'(out_addr0), 32'(e.addr));
        check("addr_dither", 32'(out_addr1), 32'(e.addr));
        check("valid_dither", 32'(out_valid1), 1);
      end
    end
    @(negedge clk);
  endtask

  task automatic set_vec(input vec_t v, input logic [AW-1:0] a);
    in_r = v.r; in_g = v.g; in_b = v.b;
    in_x_lo = v.x; in_y_lo = v.y;
    tab_e0 = v.e0; tab_e1 = v.e1;
    in_addr = a;
  endtask

  task automatic wait_accept();
    int n = 0;
    while (!in_ready0 && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready0) check("accept_timeout", 32'(in_ready0), 1);
    else tick();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(sb.size()), 0);
  endtask

  initial begin
    int sent;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_r = '0; in_g = '0; in_b = '0; in_x_lo = '0; in_y_lo = '0; in_addr = '0;

    vecs[0] = '{16'h1000, 16'h0800, 16'h0000, 2'd0, 2'd0, 16'hFC00, 16'hFC00};
    vecs[1] = '{16'hF000, 16'h3000, 16'h0FFF, 2'd0, 2'd0, 16'h07FF, 16'h07FF};
    vecs[2] = '{16'h0040, 16'h0040, 16'h0040, 2'd0, 2'd0, 16'h0020, 16'h0020};
    vecs[3] = '{16'h0040, 16'h0040, 16'h0040, 2'd1, 2'd0, 16'h0020, 16'h0821};
    vecs[4] = '{16'h0FFF, 16'h0FFF, 16'h0FFF, 2'd3, 2'd3, 16'hFFFF, 16'hFFFF};
    vecs[5] = '{16'h0078, 16'h0078, 16'h0078, 2'd0, 2'd3, 16'h0020, 16'h0841};
    vecs[6] = '{16'h7FFF, 16'h8000, 16'h0FFF, 2'd2, 2'd1, 16'hF81F, 16'hF81F};
    vecs[7] = '{16'h07C0, 16'h03F0, 16'h0170, 2'd3, 2'd2, 16'h79E2, 16'h8203};

    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid0), 0);
    check("rst_valid_d", 32'(out_valid1), 0);
    check("rst_pixel", 32'(out_pixel0), 0);
    check("rst_addr", 32'(out_addr1), 0);
    rst_n = 1'b1;
    check("ready_after_reset", 32'(in_ready0), 1);

    // Single fragments: exact latency and known-answer pixels.
    for (int i = 0; i < 8; i++) begin
      set_vec(vecs[i], AW'(24'h100000 + i));
      in_valid = 1'b1; tab_mode = 1'b1;
      check("tab_ready", 32'(in_ready0), 1);
      tick();
      in_valid = 1'b0; tab_mode = 1'b0;
      check("latency_c1", 32'(out_valid0), 0);
      tick();
      check("latency_c2", 32'(out_valid0), 1);
      tick();
      check("tab_popped", 32'(sb.size()), 0);
    end

    // Back-to-back stream at full rate.
    tab_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_vec(vecs[i], AW'(24'h180000 + i));
      in_valid = 1'b1;
      check("stream_ready", 32'(in_ready0), 1);
      tick();
    end
    in_valid = 1'b0; tab_mode = 1'b0;
    drain(10);

    // Backpressure: two accepts fill the pipe, third waits until the sink drains.
    out_ready = 1'b0; tab_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_vec(vecs[k + 2], AW'(24'h200000 + k));
      in_valid = 1'b1;
      if (k == 2) begin
        check("bp_ready_low", 32'(in_ready0), 0);
        repeat (3) tick();
        out_ready = 1'b1;
      end
      wait_accept();
    end
    in_valid = 1'b0; tab_mode = 1'b0;
    drain(20);

    // Random handshakes on both ports against the model.
    sent = 0;
    while (sent < 10000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      in_r = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {4'h0, 12'($urandom)};
      in_g = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {4'h0, 12'($urandom)};
      in_b = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {4'h0, 12'($urandom)};
      in_x_lo = 2'($urandom); in_y_lo = 2'($urandom);
      in_addr = AW'($urandom);
      tick();
      if (last_acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain(20);

    // Reset with both stages full discards everything in flight.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_vec(vecs[k], AW'(24'h300000 + k));
      in_valid = 1'b1;
      wait_accept();
    end
    in_valid = 1'b0;
    check("full_ready_low", 32'(in_ready0), 0);
    check("full_valid", 32'(out_valid0), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid0), 0);
    check("midrst_valid_d", 32'(out_valid1), 0);
    check("midrst_pixel", 32'(out_pixel1), 0);
    check("midrst_addr", 32'(out_addr0), 0);
    sb.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    check("ready_after_midrst", 32'(in_ready0), 1);
    repeat (5) begin
      tick();
      check("no_stale", 32'(out_valid0), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
